// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_bus_ctrl: CPU-to-memory bus controller for flash (RO) and SRAM (RW)  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mem_bus_ctrl #(
  parameter int FLASH_WAIT = 3,
  parameter int SRAM_WAIT  = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_byte,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_fault,
  output logic        mem_cs_flash,
  output logic        mem_cs_sram,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [3:0]    be_q, be_d;
  logic          we_q, we_d;
  logic          flash_q, flash_d;
  logic          byte_q, byte_d;
  logic          fault_q, fault_d;

  logic          hit_flash, hit_sram, req_fault;
  logic [7:0]    rd_lane;
  logic          in_access;

  assign hit_flash = (cpu_addr[31:17] == 15'h0001);
  assign hit_sram  = (cpu_addr[31:16] == 16'h2000);
  assign req_fault = (!hit_flash && !hit_sram) || (hit_flash && cpu_wr) ||
                     (!cpu_byte && (cpu_addr[1:0] != 2'b00)) || (cpu_rd && cpu_wr);
  assign rd_lane   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    we_d    = we_q;
    flash_d = flash_q;
    byte_d  = byte_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_rd || cpu_wr) begin
          addr_d  = cpu_addr;
          byte_d  = cpu_byte;
          we_d    = cpu_wr;
          flash_d = hit_flash;
          fault_d = req_fault;
          wdata_d = cpu_byte ? {4{cpu_wdata[7:0]}} : cpu_wdata;
          be_d    = cpu_byte ? (4'b0001 << cpu_addr[1:0]) : 4'b1111;
          if (req_fault) begin
            state_d = S_RESP;
            rdata_d = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = hit_flash ? CW'(FLASH_WAIT) : CW'(SRAM_WAIT);
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          // Writes leave the last load value visible to the CPU.
          if (!we_q) rdata_d = byte_q ? {24'h0, rd_lane} : mem_rdata;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      flash_q <= 1'b0;
      byte_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      flash_q <= flash_d;
      byte_q  <= byte_d;
      fault_q <= fault_d;
    end
  end

  // Strobes decode from the state register so reset removes them at once.
  assign in_access    = (state_q == S_ACCESS);
  assign cpu_ready    = (state_q == S_RESP);
  assign cpu_fault    = cpu_ready && fault_q;
  assign cpu_rdata    = rdata_q;
  assign mem_cs_flash = in_access && flash_q;
  assign mem_cs_sram  = in_access && !flash_q;
  assign mem_we       = in_access && we_q;
  assign mem_be       = in_access ? be_q : 4'b0000;
  assign mem_addr     = {addr_q[31:2], 2'b00};
  assign mem_wdata    = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_bus_ctrl: directed scoreboard bench for mem_bus_ctrl            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_mem_bus_ctrl;

  localparam int FW = 3;
  localparam int SW = 1;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_rd, cpu_wr, cpu_byte, cpu_ready, cpu_fault;
  logic        mem_cs_flash, mem_cs_sram, mem_we;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.FLASH_WAIT(FW), .SRAM_WAIT(SW)) dut (
    .clk(clk), .n_reset(n_reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_byte(cpu_byte), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_fault(cpu_fault),
    .mem_cs_flash(mem_cs_flash), .mem_cs_sram(mem_cs_sram), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] lat;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        prev_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // cpu_ready must never stay high two cycles running.
  always @(negedge clk) begin
    if (n_reset && cpu_ready) check("ready_not_consecutive", 32'(prev_ready), 32'h0);
    prev_ready = n_reset ? cpu_ready : 1'b0;
  end

  function automatic exp_t model(input logic rd, input logic wr, input logic bt,
                                 input logic [31:0] addr, input logic [31:0] mrd);
    exp_t e;
    logic flash, sram, flt;
    flash = (addr >= 32'h0002_0000) && (addr <= 32'h0003_FFFF);
    sram  = (addr >= 32'h2000_0000) && (addr <= 32'h2000_FFFF);
    flt   = !(flash || sram) || (flash && wr) || (!bt && addr[1:0] != 2'b00) || (rd && wr);
    e.fault = flt;
    e.lat   = flt ? 32'd1 : (flash ? 32'(FW + 2) : 32'(SW + 2));
    if (flt)     e.rdata = 32'h0;
    else if (wr) e.rdata = last_rdata;
    else if (bt) e.rdata = (mrd >> (8 * addr[1:0])) & 32'hFF;
    else         e.rdata = mrd;
    return e;
  endfunction

  task automatic do_req(input string tag, input logic rd, input logic wr, input logic bt,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] mrd, input logic perturb);
    exp_t        e;
    logic        flash, flt, got;
    logic [3:0]  be;
    logic [31:0] wexp;
    int          ncs;
    e     = model(rd, wr, bt, addr, mrd);
    flt   = e.fault;
    flash = (addr[31:17] == 15'h0001);
    be    = bt ? (4'b0001 << addr[1:0]) : 4'hF;
    wexp  = bt ? {4{wd[7:0]}} : wd;
    sb.push_back(e);
    @(negedge clk);
    cpu_addr = addr; cpu_wdata = wd; cpu_rd = rd; cpu_wr = wr; cpu_byte = bt; mem_rdata = mrd;
    @(posedge clk);
    ncs = 0;
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (perturb && k == 1) begin
        cpu_addr = 32'hDEAD_BEEF; cpu_wdata = ~wd; cpu_byte = ~bt;
      end
      if (cpu_ready) begin
        got = 1'b1;
        e   = sb.pop_front();
        check({tag, " latency"}, 32'(k), e.lat);
        check({tag, " rdata"}, cpu_rdata, e.rdata);
        check({tag, " fault"}, 32'(cpu_fault), 32'(e.fault));
        check({tag, " cs_cycles"}, 32'(ncs), flt ? 32'h0 : e.lat - 32'd1);
        last_rdata = e.rdata;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
      end else if (mem_cs_flash || mem_cs_sram) begin
        ncs++;
        check({tag, " cs_flash"}, 32'(mem_cs_flash), 32'(flash));
        check({tag, " cs_sram"}, 32'(mem_cs_sram), 32'(!flash));
        check({tag, " we"}, 32'(mem_we), 32'(wr));
        check({tag, " be"}, 32'(mem_be), 32'(be));
        check({tag, " addr"}, mem_addr, {addr[31:2], 2'b00});
        if (wr) check({tag, " wdata"}, mem_wdata, wexp);
      end else begin
        check({tag, " idle_strobes"}, {27'h0, mem_we, mem_be}, 32'h0);
      end
    end
    check({tag, " completed"}, 32'(got), 32'h1);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1, r2, nready;
    exp_t e;
    n_reset = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_byte = 1'b0; mem_rdata = '0;
    #23;
    check("reset ready", 32'(cpu_ready), 32'h0);
    check("reset rdata", cpu_rdata, 32'h0);
    check("reset strobes", {26'h0, mem_cs_flash, mem_cs_sram, mem_we, mem_be}, 32'h0);
    check("reset addr", mem_addr, 32'h0);
    check("reset wdata", mem_wdata, 32'h0);
    @(negedge clk);
    n_reset = 1'b1;

    do_req("flash_word_rd", 1, 0, 0, 32'h0002_0000, 32'h0, 32'hE3A0_1005, 0);
    do_req("sram_byte_wr", 0, 1, 1, 32'h2000_0003, 32'h0000_00AB, 32'h0, 1);
    do_req("sram_byte_rd", 1, 0, 1, 32'h2000_0001, 32'h0, 32'h1122_3344, 0);
    do_req("sram_word_wr", 0, 1, 0, 32'h2000_0004, 32'h1234_5678, 32'h0, 0);
    do_req("sram_word_rd", 1, 0, 0, 32'h2000_0004, 32'h0, 32'hCAFE_BABE, 0);
    do_req("flash_top_rd", 1, 0, 0, 32'h0003_FFFC, 32'h0, 32'h0F0F_5A5A, 0);
    do_req("sram_top_byte", 1, 0, 1, 32'h2000_FFFF, 32'h0, 32'h9A00_0000, 0);
    do_req("flt_flash_wr", 0, 1, 0, 32'h0002_0010, 32'h5555_5555, 32'h0, 0);
    do_req("flt_unmapped", 1, 0, 0, 32'h1000_0000, 32'h0, 32'h7777_7777, 0);
    do_req("flt_misalign", 1, 0, 0, 32'h2000_0002, 32'h0, 32'h7777_7777, 0);
    do_req("flt_rd_wr", 1, 1, 0, 32'h2000_0000, 32'h0, 32'h7777_7777, 0);
    do_req("flt_below_flash", 1, 0, 0, 32'h0001_FFFC, 32'h0, 32'h7777_7777, 0);
    do_req("flt_above_sram", 1, 0, 1, 32'h2001_0000, 32'h0, 32'h7777_7777, 0);
    do_req("flash_byte_rd", 1, 0, 1, 32'h0002_0102, 32'h0, 32'hA1B2_C3D4, 0);

    // Reset pulse in the middle of an SRAM write.
    @(negedge clk);
    cpu_addr = 32'h2000_0008; cpu_wdata = 32'h55AA_55AA; cpu_wr = 1'b1; cpu_byte = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid we_before", 32'(mem_we), 32'h1);
    #1 n_reset = 1'b0;
    #1;
    check("rst_mid we_drop", 32'(mem_we), 32'h0);
    check("rst_mid cs_drop", 32'(mem_cs_sram), 32'h0);
    check("rst_mid no_ready", 32'(cpu_ready), 32'h0);
    cpu_wr = 1'b0;
    last_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    nready = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (cpu_ready) nready++;
    end
    check("rst_mid ready_count", 32'(nready), 32'h0);
    do_req("post_rst_rd", 1, 0, 0, 32'h2000_0008, 32'h0, 32'h0BAD_F00D, 0);

    // Request held across completion is taken again after one IDLE cycle.
    @(negedge clk);
    cpu_addr = 32'h2000_0010; cpu_byte = 1'b0; cpu_rd = 1'b1; mem_rdata = 32'h600D_CAFE;
    sb.push_back(model(1, 0, 0, 32'h2000_0010, 32'h600D_CAFE));
    sb.push_back(model(1, 0, 0, 32'h2000_0010, 32'h600D_CAFE));
    @(posedge clk);
    r1 = 0; r2 = 0;
    for (int k = 1; k <= 30 && r2 == 0; k++) begin
      @(negedge clk);
      if (cpu_ready) begin
        if (r1 == 0) r1 = k;
        else r2 = k;
        e = sb.pop_front();
        check("b2b rdata", cpu_rdata, e.rdata);
        if (r2 != 0) cpu_rd = 1'b0;
      end
    end
    cpu_rd = 1'b0;
    check("b2b first_lat", 32'(r1), 32'(SW + 2));
    check("b2b gap", 32'(r2 - r1), 32'(SW + 3));
    last_rdata = 32'h600D_CAFE;
    @(negedge clk);
    @(negedge clk);
    check("rdata_hold", cpu_rdata, last_rdata);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
